div_core: RTL

Iterative 32-bit radix-2 restoring divider that serves as the responder behind the EX-stage divide controller of the MIPS core. It accepts a DIV/DIVU request over a start/ready handshake, runs one quotient bit per cycle, and returns `{remainder, quotient}` for the HI/LO write path. While the request is outstanding, it drives a combinational stall to the pipeline.

---
 rtl/div_core_pkg.sv | 25 ++
 rtl/div_step.sv | 23 ++
 rtl/div_core.sv | 137 +++++++++++++
 3 files changed

// File: rtl/div_core_pkg.sv
// Shared types and constants for the iterative radix-2 restoring divider.
package div_core_pkg;

    localparam int unsigned DIV_WIDTH  = 32;
    localparam int unsigned DIV_CYCLES = 32;
    localparam int unsigned CNT_W      = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'd0,
        DIV_ON      = 2'd1,
        DIV_DIVZERO = 2'd2,
        DIV_DONE    = 2'd3
    } div_state_e;

    // HI carries the remainder, LO the quotient.
    typedef struct packed {
        logic [DIV_WIDTH-1:0] hi;
        logic [DIV_WIDTH-1:0] lo;
    } div_result_t;

    function automatic logic [DIV_WIDTH-1:0] neg_if(input logic neg, input logic [DIV_WIDTH-1:0] x);
        return neg ? DIV_WIDTH'(-x) : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] dvs,
    input  logic             dvd_bit,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // One extra bit above the shifted remainder makes the trial sign unambiguous.
    always_comb begin
        shifted  = {rem, dvd_bit};
        trial    = shifted - (WIDTH+2)'(dvs);
        q_bit    = ~trial[WIDTH+1];
        rem_next = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div_core.sv
// Iterative 32-bit DIV/DIVU responder: one quotient bit per cycle, {remainder, quotient} result.
module div_core
    import div_core_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               stall_o
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH:0]   rem_q, rem_d, step_rem;
    logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, quo_fin;
    logic             neg_dvd_q, neg_dvd_d, neg_dvs_q, neg_dvs_d;
    logic             step_q;
    div_result_t      result_q, result_d;
    logic             ready_q, ready_d, busy_q, busy_d;
    logic             accept, dvs_zero, last_step;

    assign accept    = start_i & ~flush;
    assign dvs_zero  = (opdata2_i == '0);
    assign last_step = (count_q == CNT_W'(DIV_CYCLES - 1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .dvs      (dvs_q),
        .dvd_bit  (dvd_q[WIDTH-1]),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= DIV_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE:    if (accept) state_d = dvs_zero ? DIV_DIVZERO : DIV_ON;
            DIV_ON:      if (last_step) state_d = DIV_DONE;
            DIV_DIVZERO: state_d = DIV_DONE;
            DIV_DONE:    state_d = DIV_IDLE;
            default:     state_d = DIV_IDLE;
        endcase
        if (flush) state_d = DIV_IDLE;
    end

    // dvd shifts dividend bits out of the top while quotient bits enter at the bottom.
    always_comb begin
        count_d   = count_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        neg_dvd_d = neg_dvd_q;
        neg_dvs_d = neg_dvs_q;
        result_d  = result_q;
        ready_d   = 1'b0;
        busy_d    = (state_d != DIV_IDLE);
        quo_fin   = {dvd_q[WIDTH-2:0], step_q};
        case (state_q)
            DIV_IDLE: begin
                if (accept) begin
                    neg_dvd_d = signed_i & opdata1_i[WIDTH-1];
                    neg_dvs_d = signed_i & opdata2_i[WIDTH-1];
                    dvs_d     = neg_if(neg_dvs_d, opdata2_i);
                    dvd_d     = dvs_zero ? opdata1_i : neg_if(neg_dvd_d, opdata1_i);
                    rem_d     = '0;
                    count_d   = '0;
                end
            end
            DIV_ON: begin
                rem_d   = step_rem;
                dvd_d   = quo_fin;
                count_d = count_q + CNT_W'(1);
                if (last_step) begin
                    result_d.lo = neg_if(neg_dvd_q ^ neg_dvs_q, quo_fin);
                    result_d.hi = neg_if(neg_dvd_q, step_rem[WIDTH-1:0]);
                    ready_d     = 1'b1;
                end
            end
            DIV_DIVZERO: begin
                // Raw dividend was kept in dvd for this path.
                result_d.hi = dvd_q;
                result_d.lo = '1;
                ready_d     = 1'b1;
            end
            DIV_DONE: count_d = '0;
            default: ;
        endcase
        if (flush) begin
            count_d  = '0;
            ready_d  = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            neg_dvd_q <= neg_dvd_d;
            neg_dvs_q <= neg_dvs_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = busy_q;
    assign stall_o  = (start_i & ~ready_q) & ~flush;

endmodule
